// File: rtl/hex_loader.sv
// hex_loader: streams a length-prefixed little-endian word image from a byte
// handshake into memory writes, holding the CPU in reset until the load ends.
// Ports: i_clk, i_rst (async, active-low); i_byte_valid/i_byte_data in,
// o_byte_ready out; o_mem_valid/o_mem_we/o_mem_addr/o_mem_data write port;
// o_cpu_rst, o_done, o_error status.
// Option: HEX_LOADER_CHECKSUM_EN adds a 4-byte sum trailer checked in CSUM.
module hex_loader #(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 65536
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_mem_valid,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_error
);

`ifdef HEX_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR, S_LOAD, S_CSUM, S_DONE, S_ERR
  } state_e;
`else
  typedef enum logic [2:0] {
    S_HDR, S_LOAD, S_DONE, S_ERR
  } state_e;
`endif

  localparam logic [31:0] MAX_L = 32'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wv_q, wv_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef HEX_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  logic        rdy;
  logic        xfer;
  logic        last;
  logic [31:0] word;

  // Ready is forced low while reset is held, not just after the first edge.
  assign rdy  = i_rst &&
                (state_q == S_HDR || state_q == S_LOAD);
  assign xfer = i_byte_valid && rdy;
  assign last = (cnt_q == 2'd3);
  assign word = {i_byte_data, asm_q};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_HDR;
      cnt_q   <= '0;
      asm_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      wv_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef HEX_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wv_q    <= wv_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef HEX_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wv_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef HEX_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (xfer) begin
      cnt_d = cnt_q + 2'd1;
      // Only the first three bytes are stored; the fourth completes `word`.
      unique case (cnt_q)
        2'd0:    asm_d[7:0]   = i_byte_data;
        2'd1:    asm_d[15:8]  = i_byte_data;
        2'd2:    asm_d[23:16] = i_byte_data;
        default: ;
      endcase
      if (last) begin
        unique case (state_q)
          S_HDR: begin
            len_d = word;
            if (word == 32'd0)
`ifdef HEX_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            else if (word > MAX_L)
              state_d = S_ERR;
            else
              state_d = S_LOAD;
          end
          S_LOAD: begin
            wv_d    = 1'b1;
            waddr_d = idx_q;
            wdata_d = word;
            idx_d   = idx_q + 1'b1;
`ifdef HEX_LOADER_CHECKSUM_EN
            sum_d   = sum_q + word;
`endif
            if (32'(idx_q) + 32'd1 == len_q)
`ifdef HEX_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
          end
`ifdef HEX_LOADER_CHECKSUM_EN
          S_CSUM: begin
            state_d = (word == sum_q) ? S_DONE : S_ERR;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign o_byte_ready = rdy;
  assign o_mem_valid  = wv_q;
  assign o_mem_we     = wv_q;
  assign o_mem_addr   = waddr_q;
  assign o_mem_data   = wdata_q;
  assign o_cpu_rst    = (state_q != S_DONE);
  assign o_done       = (state_q == S_DONE);
  assign o_error      = (state_q == S_ERR);

endmodule

// File: tb/tb_hex_loader.sv
// tb_hex_loader: table-driven checks of hex_loader (MAX_WORDS=4) plus
// hand sequences for asynchronous reset.
module tb_hex_loader;

  logic        i_clk;
  logic        i_rst;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        o_mem_valid;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic        o_cpu_rst;
  logic        o_done;
  logic        o_error;

  hex_loader #(
    .ADDR_W    (16),
    .MAX_WORDS (4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_mem_valid  (o_mem_valid),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_cpu_rst    (o_cpu_rst),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        mv;
    logic [15:0] a;
    logic [31:0] w;
    logic        rdy;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic row(input logic rst, input logic v, input logic [7:0] d,
                     input logic mv, input logic [15:0] a,
                     input logic [31:0] w, input logic rdy,
                     input logic dn, input logic er);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.mv = mv; r.a = a; r.w = w;
    r.rdy = rdy; r.dn = dn; r.er = er;
    vecs.push_back(r);
  endtask

  task automatic rst_row();
    row(1'b0, 1'b1, 8'h55, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Two-word image: writes 0x12345678 @0 and 0xDEADBEEF @1.
  task automatic img(input bit tog, input int nbytes);
    logic [7:0] b [12];
    logic mv, rdy, dn;
    b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
          8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < nbytes; i++) begin
      mv  = (i == 7) || (i == 11);
      dn  = (i == 11);
      rdy = !dn;
      row(1'b1, 1'b1, b[i], mv, (i == 11) ? 16'd1 : 16'd0,
          (i == 7) ? 32'h12345678 : 32'hDEADBEEF, rdy, dn, 1'b0);
      if (tog)
        row(1'b1, 1'b0, 8'hA5, 1'b0, 16'h0, 32'h0, rdy, dn, 1'b0);
    end
  endtask

  task automatic check_now(input string tag, input vec_t r);
    chk({tag, " rdy"}, 32'(o_byte_ready), 32'(r.rdy));
    chk({tag, " mv"}, 32'(o_mem_valid), 32'(r.mv));
    chk({tag, " we"}, 32'(o_mem_we), 32'(r.mv));
    chk({tag, " done"}, 32'(o_done), 32'(r.dn));
    chk({tag, " err"}, 32'(o_error), 32'(r.er));
    chk({tag, " cpu_rst"}, 32'(o_cpu_rst), 32'(!r.dn));
    if (r.mv || !r.rst) begin
      chk({tag, " addr"}, 32'(o_mem_addr), 32'(r.a));
      chk({tag, " data"}, o_mem_data, r.w);
    end
  endtask

  initial begin
    vec_t r;
    i_rst = 1'b0;
    i_byte_valid = 1'b0;
    i_byte_data = 8'h00;

    rst_row();
    img(1'b0, 12);
    for (int i = 0; i < 2; i++)
      row(1'b1, 1'b1, 8'h99, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    // Empty image.
    rst_row();
    for (int i = 0; i < 4; i++)
      row(1'b1, 1'b1, 8'h00, 1'b0, 16'h0, 32'h0, i != 3, i == 3, 1'b0);
    row(1'b1, 1'b1, 8'h07, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    // L=5 exceeds MAX_WORDS=4.
    rst_row();
    row(1'b1, 1'b1, 8'h05, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      row(1'b1, 1'b1, 8'h00, 1'b0, 16'h0, 32'h0, i != 2, 1'b0, i == 2);
    for (int i = 0; i < 20; i++)
      row(1'b1, 1'b1, 8'(i), 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    // L=4 is exactly the limit and loads.
    rst_row();
    row(1'b1, 1'b1, 8'h04, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      row(1'b1, 1'b1, 8'h00, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    row(1'b1, 1'b1, 8'h11, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    row(1'b1, 1'b1, 8'h22, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    row(1'b1, 1'b1, 8'h33, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    row(1'b1, 1'b1, 8'h44, 1'b1, 16'h0, 32'h44332211, 1'b1, 1'b0, 1'b0);
    row(1'b1, 1'b0, 8'h00, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Valid toggling every other cycle.
    rst_row();
    img(1'b1, 12);
    // Reset after 6 bytes, then the full image.
    rst_row();
    img(1'b0, 6);
    rst_row();
    img(1'b0, 12);

    for (int k = 0; k < vecs.size(); k++) begin
      r = vecs[k];
      @(negedge i_clk);
      i_rst = r.rst;
      i_byte_valid = r.v;
      i_byte_data = r.d;
      @(posedge i_clk);
      #1;
      check_now($sformatf("v%0d", k), r);
    end

    // Asynchronous reset with no clock edge between assert and check.
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    chk("async done", 32'(o_done), 32'd0);
    chk("async cpu_rst", 32'(o_cpu_rst), 32'd1);
    chk("async rdy", 32'(o_byte_ready), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    begin
      logic [7:0] b [8];
      b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      for (int i = 0; i < 8; i++) begin
        i_byte_valid = 1'b1;
        i_byte_data = b[i];
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
      end
    end
    i_byte_valid = 1'b0;
    chk("strobe mv", 32'(o_mem_valid), 32'd1);
    chk("strobe data", o_mem_data, 32'h12345678);
    #1;
    i_rst = 1'b0;
    #1;
    chk("async mv", 32'(o_mem_valid), 32'd0);
    chk("async addr", 32'(o_mem_addr), 32'd0);
    chk("async data", o_mem_data, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post rdy", 32'(o_byte_ready), 32'd1);
    chk("post mv", 32'(o_mem_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/hex_loader.md
HEX_LOADER -- requirements
Module: hex_loader

Interface
REQ-001 Parameter ADDR_W, default 16, memory word-address width.
REQ-002 Parameter MAX_WORDS, default 65536, largest image accepted, in words.
REQ-003 i_clk  in  1  sole clock; all state on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 i_byte_valid  in  1  input byte present.
REQ-006 i_byte_data  in  8  image byte.
REQ-007 o_byte_ready  out  1  loader accepts byte; a transfer occurs when valid and ready are both high.
REQ-008 o_mem_valid  out  1  one-cycle memory write strobe.
REQ-009 o_mem_we  out  1  write enable; equals o_mem_valid.
REQ-010 o_mem_addr  out  ADDR_W  word address of the write.
REQ-011 o_mem_data  out  32  word to write.
REQ-012 o_cpu_rst  out  1  processor reset request, active-high; held until load completes.
REQ-013 o_done  out  1  image loaded successfully.
REQ-014 o_error  out  1  load aborted.

Function
REQ-015 Image format: 4-byte little-endian length L in words, then L words, each 4 bytes little-endian.
REQ-016 States: HDR, LOAD, DONE, ERR; reset enters HDR with byte counter 0.
REQ-017 HDR: accept 4 bytes into L; on the 4th byte go to DONE if L=0, ERR if L>MAX_WORDS, else LOAD.
REQ-018 LOAD: assemble bytes into a word, byte 0 into bits 7:0; word index starts at 0.
REQ-019 On acceptance of a word's 4th byte: o_mem_valid=1 on the next cycle only, o_mem_addr=word index, o_mem_data=assembled word; the index then increments.
REQ-020 Write latency is exactly 1 cycle from 4th-byte handshake; back-to-back bytes every cycle are sustained without stall.
REQ-021 After the write of word L-1 the FSM enters DONE on the same edge that raises o_mem_valid for that word.
REQ-022 o_byte_ready=1 in HDR and LOAD, 0 in DONE and ERR; bytes offered in DONE/ERR are ignored.
REQ-023 DONE: o_done=1, o_cpu_rst=0; held until reset.
REQ-024 ERR: o_error=1, o_cpu_rst=1, no further memory writes; held until reset.
REQ-025 o_cpu_rst=1 in HDR, LOAD, ERR.
REQ-026 Word index is ADDR_W bits; no wrap occurs because L<=MAX_WORDS<=2^ADDR_W.
REQ-027 i_byte_valid low mid-word: partial byte count and assembled bytes retained indefinitely.

Reset
REQ-028 While i_rst=0: o_byte_ready=0, o_mem_valid=0, o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_cpu_rst=1, o_done=0, o_error=0.
REQ-029 Reset mid-load discards partial word, length and index; next image starts from HDR; words already written are not erased.

Configuration
REQ-030 Macro HEX_LOADER_CHECKSUM_EN defined: after word L-1 a state CSUM accepts a 4-byte little-endian trailer; enter DONE if it equals the mod-2^32 sum of all L words, else ERR; L=0 also requires trailer value 0.
REQ-031 Macro HEX_LOADER_CHECKSUM_EN undefined: no trailer, no CSUM state, behaviour per REQ-021.

Verification
REQ-032 Bytes 02 00 00 00 78 56 34 12 EF BE AD DE, valid every cycle -> writes addr0=0x12345678, addr1=0xDEADBEEF, each 1 cycle after 4th byte; o_done=1, o_cpu_rst=0.
REQ-033 Header 00 00 00 00 -> no writes, o_done=1 the cycle after the 4th byte (checksum build: after trailer 00 00 00 00).
REQ-034 MAX_WORDS=4, header 05 00 00 00 -> o_error=1, o_byte_ready=0, no writes for 20 further valid bytes.
REQ-035 Same image as REQ-032 with i_byte_valid toggling every other cycle -> identical writes and data.
REQ-036 i_rst=0 asynchronously after 6 bytes, then full REQ-032 image -> writes addr0/addr1 only with correct data, no spurious strobe.
REQ-037 Checksum build: REQ-032 image + trailer 67 15 E2 F0 -> o_done=1; trailer 00 00 00 00 -> o_error=1.
